// File: rtl/life_pkg.sv
// -----------------------------------------------------------------------------
// life_pkg
// Shared types and widths for the life-event request path.
//   life_state_t : hit-protection state of the player (VULN / INVULN / DEAD)
//   LIVES_W      : width of the lives count coming from the lives controller
//   KIT_CNT_W    : width of the pending life-kit counter
//   INV_CNT_W    : width of the invulnerability seconds counter
//   lives_sum()  : lives + pending kits, one bit wider so the sum never wraps
// -----------------------------------------------------------------------------
package life_pkg;

  typedef enum logic [1:0] {
    VULN   = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } life_state_t;

  localparam int LIVES_W   = 4;
  localparam int KIT_CNT_W = 2;
  localparam int INV_CNT_W = 4;

  // Lives a player would end up with if every pending kit were granted.
  function automatic logic [LIVES_W:0] lives_sum(
    input logic [LIVES_W-1:0]   lives,
    input logic [KIT_CNT_W-1:0] kit_pend
  );
    return {1'b0, lives} + {{(LIVES_W - KIT_CNT_W + 1){1'b0}}, kit_pend};
  endfunction

endpackage

// File: rtl/life_kit_queue.sv
// -----------------------------------------------------------------------------
// life_kit_queue
// Holds collected life kits until the lives controller may take them, granting
// at most one increment per OneSecPulse window. Kits that could never be
// granted (queue full, or lives plus pending already at the ceiling) are
// discarded with a kit_dropped pulse.
//
// Ports:
//   clk              system clock
//   reset            synchronous, active-high reset
//   life_kit_pickup  one-cycle pulse per kit collected
//   OneSecPulse      1 Hz pulse; reopens the increment window
//   lives            current lives from the lives controller
//   dead             player is in DEAD: flush and stay silent
//   hold_issue       a decrement is going out this cycle; increment waits
//   increment_life   one-cycle increment request
//   kit_dropped      one-cycle pulse when a kit is discarded
// -----------------------------------------------------------------------------
module life_kit_queue
  import life_pkg::*;
#(
  parameter int MAX_LIVES       = 9,
  parameter int KIT_QUEUE_DEPTH = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               life_kit_pickup,
  input  logic               OneSecPulse,
  input  logic [LIVES_W-1:0] lives,
  input  logic               dead,
  input  logic               hold_issue,
  output logic               increment_life,
  output logic               kit_dropped
);

  localparam logic [KIT_CNT_W-1:0] DEPTH_C = KIT_CNT_W'(KIT_QUEUE_DEPTH);
  localparam logic [LIVES_W:0]     MAX_C   = (LIVES_W + 1)'(MAX_LIVES);

  logic [KIT_CNT_W-1:0] kit_pend_q;
  logic                 kit_window_used_q;

  logic [LIVES_W:0] lives_plus_pend;
  logic             no_room;
  logic             accept;
  logic             drop;
  logic             issue;

  assign lives_plus_pend = lives_sum(lives, kit_pend_q);

  // A kit is refused when it could never be granted: either the queue is
  // full or the kits already pending would take lives to the ceiling.
  assign no_room = (kit_pend_q == DEPTH_C) || (lives_plus_pend >= MAX_C);
  assign accept  = !dead && life_kit_pickup && !no_room;
  assign drop    = !dead && life_kit_pickup &&  no_room;

  // The window flag is registered, so a OneSecPulse only reopens the window
  // from the following cycle onward.
  assign issue = !dead && (kit_pend_q != '0) && !kit_window_used_q && !hold_issue;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of order.
    if (reset) begin
      kit_pend_q        <= '0;
      kit_window_used_q <= 1'b0;
    end else if (dead) begin
      kit_pend_q        <= '0;
      kit_window_used_q <= 1'b0;
    end else begin
      // Pickup and issue in the same cycle cancel out.
      if (accept && !issue) begin
        kit_pend_q <= kit_pend_q + KIT_CNT_W'(1);
      end else if (issue && !accept) begin
        kit_pend_q <= kit_pend_q - KIT_CNT_W'(1);
      end

      if (issue) begin
        kit_window_used_q <= 1'b1;
      end else if (OneSecPulse) begin
        kit_window_used_q <= 1'b0;
      end
    end
  end

  // Nothing leaves the block while reset is asserted.
  assign increment_life = issue && !reset;
  assign kit_dropped    = drop  && !reset;

endmodule

// File: rtl/life_event_arbiter.sv
// -----------------------------------------------------------------------------
// life_event_arbiter
// Request side of the lives interface. Converts raw gameplay events into
// clean single-cycle decrement_life / increment_life requests:
//   - a hit (bomb or enemy) in VULN issues one decrement and starts
//     INVULN_SECONDS seconds of invulnerability, so a held hit level yields
//     one decrement per protection period;
//   - life kits are queued in life_kit_queue and granted one per second;
//   - lives_over moves the player to DEAD, where nothing is requested until
//     reset.
// Optional build macro LIFE_BLINK_EN adds a sprite blink strobe during
// INVULN; without it player_blink is tied low.
//
// Ports:
//   clk              system clock
//   reset            synchronous, active-high reset
//   bomb_hit         level: player overlaps an explosion
//   enemy_hit        level: player overlaps an enemy
//   life_kit_pickup  one-cycle pulse per kit collected
//   OneSecPulse      one-cycle pulse, 1 Hz
//   lives            current lives from the lives controller
//   lives_over       lives == 0 from the lives controller
//   decrement_life   one-cycle request
//   increment_life   one-cycle request
//   invulnerable     high while in INVULN
//   player_blink     sprite hide strobe
//   kit_dropped      one-cycle pulse when a kit is discarded
// -----------------------------------------------------------------------------
module life_event_arbiter
  import life_pkg::*;
#(
  parameter int INVULN_SECONDS    = 2,
  parameter int MAX_LIVES         = 9,
  parameter int KIT_QUEUE_DEPTH   = 3,
  parameter int BLINK_HALF_CYCLES = 3125000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bomb_hit,
  input  logic               enemy_hit,
  input  logic               life_kit_pickup,
  input  logic               OneSecPulse,
  input  logic [LIVES_W-1:0] lives,
  input  logic               lives_over,
  output logic               decrement_life,
  output logic               increment_life,
  output logic               invulnerable,
  output logic               player_blink,
  output logic               kit_dropped
);

  // Elaboration-time range checks on the configuration.
  if (INVULN_SECONDS < 1 || INVULN_SECONDS > 15) begin : g_bad_invuln
    $error("INVULN_SECONDS must be in 1..15");
  end
  if (KIT_QUEUE_DEPTH < 1 || KIT_QUEUE_DEPTH > 3) begin : g_bad_depth
    $error("KIT_QUEUE_DEPTH must be in 1..3");
  end
  if (BLINK_HALF_CYCLES < 1) begin : g_bad_blink
    $error("BLINK_HALF_CYCLES must be at least 1");
  end

  localparam logic [INV_CNT_W-1:0] INV_LOAD = INV_CNT_W'(INVULN_SECONDS);

  life_state_t          state_q, state_d;
  logic [INV_CNT_W-1:0] inv_cnt_q, inv_cnt_d;
  logic                 hit;
  logic                 dec_req;

  assign hit = bomb_hit || enemy_hit;

  // ---------------------------------------------------------------------------
  // Hit-protection FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= VULN;
      inv_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      inv_cnt_q <= inv_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Hit-protection FSM: next state and decrement request
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    inv_cnt_d = inv_cnt_q;
    dec_req   = 1'b0;

    unique case (state_q)
      VULN: begin
        if (lives_over) begin
          state_d = DEAD;
        end else if (hit) begin
          dec_req   = 1'b1;
          inv_cnt_d = INV_LOAD;
          state_d   = INVULN;
        end
      end

      INVULN: begin
        // Hits are ignored here; only the seconds counter matters.
        if (lives_over) begin
          state_d   = DEAD;
          inv_cnt_d = '0;
        end else if (OneSecPulse) begin
          // The last second expiring returns to VULN at the same edge; the
          // <= 1 test also keeps the counter from wrapping below zero.
          if (inv_cnt_q <= INV_CNT_W'(1)) begin
            inv_cnt_d = '0;
            state_d   = VULN;
          end else begin
            inv_cnt_d = inv_cnt_q - INV_CNT_W'(1);
          end
        end
      end

      DEAD: begin
        inv_cnt_d = '0;
      end

      default: begin
        state_d   = VULN;
        inv_cnt_d = '0;
      end
    endcase
  end

  assign decrement_life = dec_req && !reset;
  assign invulnerable   = (state_q == INVULN) && !reset;

  // ---------------------------------------------------------------------------
  // Kit queue: decrement has priority, so the increment is held off in any
  // cycle a decrement is requested.
  // ---------------------------------------------------------------------------
  life_kit_queue #(
    .MAX_LIVES       (MAX_LIVES),
    .KIT_QUEUE_DEPTH (KIT_QUEUE_DEPTH)
  ) u_kit_queue (
    .clk             (clk),
    .reset           (reset),
    .life_kit_pickup (life_kit_pickup),
    .OneSecPulse     (OneSecPulse),
    .lives           (lives),
    .dead            (state_q == DEAD),
    .hold_issue      (dec_req),
    .increment_life  (increment_life),
    .kit_dropped     (kit_dropped)
  );

  // ---------------------------------------------------------------------------
  // Sprite blink strobe
  // ---------------------------------------------------------------------------
`ifdef LIFE_BLINK_EN
  localparam int BLINK_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_CYCLES - 1);

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_q;

  // Counter and strobe run only while INVULN persists; entering INVULN starts
  // a fresh half-period with the sprite hidden.
  always_ff @(posedge clk) begin
    if (reset || state_d != INVULN) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (state_q != INVULN) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q <= '0;
      blink_q     <= !blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
    end
  end

  assign player_blink = blink_q && !reset;
`else
  assign player_blink = 1'b0;
`endif

endmodule
